// File: rtl/rob_multiport_pkg.sv
// Shared constants and helpers for the multi-port reorder buffer slice.
// Default geometry, boolean constants and the port-select width helper live here.
package rob_multiport_pkg;

    localparam int ROB_DEPTH    = 16;
    localparam int ROB_WB_PORTS = 2;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    // Width needed to name one writeback port; never zero, even for a single port.
    function automatic int sel_w(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/rob_wb_merge.sv
// Decodes the writeback channels into per-entry hit flags and the winning port index.
// Lower port indices take priority when several channels target the same entry.
module rob_wb_merge
    import rob_multiport_pkg::*;
#(
    parameter int  DEPTH    = ROB_DEPTH,
    parameter int  WB_PORTS = ROB_WB_PORTS,
    localparam int ID_W     = $clog2(DEPTH),
    localparam int SEL_W    = sel_w(WB_PORTS)
) (
    input  logic [WB_PORTS-1:0]      wb_valid,
    input  logic [WB_PORTS*ID_W-1:0] wb_rob_id,
    output logic [DEPTH-1:0]         hit,
    output logic [SEL_W-1:0]         sel [DEPTH]
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic             hit_e;
            logic [SEL_W-1:0] sel_e;

            // Scan from the highest port down so the lowest matching port is the last writer.
            always_comb begin
                hit_e = False;
                sel_e = '0;
                for (int p = WB_PORTS - 1; p >= 0; p--) begin
                    if (wb_valid[p] && (wb_rob_id[p*ID_W +: ID_W] == ID_W'(gi))) begin
                        hit_e = True;
                        sel_e = SEL_W'(p);
                    end
                end
            end

            assign hit[gi] = hit_e;
            assign sel[gi] = sel_e;
        end
    endgenerate

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order allocate and commit, multi-port out-of-order writeback,
// full flush on branch mispredict, and two operand-query ports with writeback bypass.
module rob_multiport
    import rob_multiport_pkg::*;
#(
    parameter int  DEPTH    = ROB_DEPTH,
    parameter int  WB_PORTS = ROB_WB_PORTS,
    parameter int  DATA_W   = 32,
    parameter int  REG_W    = 5,
    localparam int ID_W     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       disp_valid,
    input  logic [REG_W-1:0]           disp_rd,
    input  logic [DATA_W-1:0]          disp_pc,
    input  logic                       disp_is_br,
    input  logic                       disp_pred_taken,
    output logic                       disp_ready,
    output logic [ID_W-1:0]            disp_rob_id,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*ID_W-1:0]   wb_rob_id,
    input  logic [WB_PORTS*DATA_W-1:0] wb_value,
    input  logic [WB_PORTS-1:0]        wb_taken,
    input  logic [WB_PORTS*DATA_W-1:0] wb_target,
    input  logic [ID_W-1:0]            qry_id_a,
    input  logic [ID_W-1:0]            qry_id_b,
    output logic                       qry_ready_a,
    output logic                       qry_ready_b,
    output logic [DATA_W-1:0]          qry_value_a,
    output logic [DATA_W-1:0]          qry_value_b,
    output logic                       cmt_valid,
    output logic [ID_W-1:0]            cmt_rob_id,
    output logic [REG_W-1:0]           cmt_rd,
    output logic [DATA_W-1:0]          cmt_value,
    output logic                       flush_valid,
    output logic [DATA_W-1:0]          flush_pc,
    output logic [ID_W:0]              count
);

    localparam int SEL_W = sel_w(WB_PORTS);
    localparam logic [ID_W:0] FULL_COUNT = (ID_W + 1)'(DEPTH);

    logic [ID_W-1:0]   head_reg;
    logic [ID_W-1:0]   tail_reg;
    logic [ID_W:0]     count_reg;
    logic [ID_W:0]     count_next;

    logic              busy_reg   [DEPTH];
    logic              ready_reg  [DEPTH];
    logic              is_br_reg  [DEPTH];
    logic              pred_reg   [DEPTH];
    logic              taken_reg  [DEPTH];
    logic [REG_W-1:0]  rd_reg     [DEPTH];
    logic [DATA_W-1:0] pc_reg     [DEPTH];
    logic [DATA_W-1:0] value_reg  [DEPTH];
    logic [DATA_W-1:0] target_reg [DEPTH];

    logic [DATA_W-1:0] wb_value_arr  [WB_PORTS];
    logic [DATA_W-1:0] wb_target_arr [WB_PORTS];
    logic [DEPTH-1:0]  wb_hit;
    logic [SEL_W-1:0]  wb_sel [DEPTH];

    logic disp_fire;
    logic commit_fire;
    logic flush_fire;

    genvar gi;
    generate
        for (gi = 0; gi < WB_PORTS; gi++) begin : g_port
            assign wb_value_arr[gi]  = wb_value[gi*DATA_W +: DATA_W];
            assign wb_target_arr[gi] = wb_target[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rob_wb_merge #(
        .DEPTH    (DEPTH),
        .WB_PORTS (WB_PORTS)
    ) u_wb_merge (
        .wb_valid  (wb_valid),
        .wb_rob_id (wb_rob_id),
        .hit       (wb_hit),
        .sel       (wb_sel)
    );

    // Commit looks only at registered state; a same-cycle writeback to the head waits a cycle.
    assign commit_fire = rdy && busy_reg[head_reg] && ready_reg[head_reg];
    assign flush_fire  = commit_fire && is_br_reg[head_reg]
                         && (pred_reg[head_reg] != taken_reg[head_reg]);
    assign disp_ready  = (count_reg != FULL_COUNT);
    assign disp_fire   = rdy && disp_valid && disp_ready && !flush_fire;
    assign disp_rob_id = tail_reg;
    assign count       = count_reg;
    assign count_next  = count_reg + (ID_W + 1)'(disp_fire) - (ID_W + 1)'(commit_fire);

    assign qry_ready_a = wb_hit[qry_id_a] ? True : ready_reg[qry_id_a];
    assign qry_value_a = wb_hit[qry_id_a] ? wb_value_arr[wb_sel[qry_id_a]] : value_reg[qry_id_a];
    assign qry_ready_b = wb_hit[qry_id_b] ? True : ready_reg[qry_id_b];
    assign qry_value_b = wb_hit[qry_id_b] ? wb_value_arr[wb_sel[qry_id_b]] : value_reg[qry_id_b];

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    busy_reg[gi]   <= False;
                    ready_reg[gi]  <= False;
                    is_br_reg[gi]  <= False;
                    pred_reg[gi]   <= False;
                    taken_reg[gi]  <= False;
                    rd_reg[gi]     <= '0;
                    pc_reg[gi]     <= '0;
                    value_reg[gi]  <= '0;
                    target_reg[gi] <= '0;
                end else if (rdy) begin
                    if (flush_fire) begin
                        busy_reg[gi] <= False;
                    end else begin
                        if (disp_fire && (tail_reg == ID_W'(gi))) begin
                            busy_reg[gi]  <= True;
                            ready_reg[gi] <= False;
                            rd_reg[gi]    <= disp_rd;
                            pc_reg[gi]    <= disp_pc;
                            is_br_reg[gi] <= disp_is_br;
                            pred_reg[gi]  <= disp_pred_taken;
                        end else if (wb_hit[gi] && busy_reg[gi]) begin
                            ready_reg[gi]  <= True;
                            value_reg[gi]  <= wb_value_arr[wb_sel[gi]];
                            taken_reg[gi]  <= wb_taken[wb_sel[gi]];
                            target_reg[gi] <= wb_target_arr[wb_sel[gi]];
                        end
                        if (commit_fire && (head_reg == ID_W'(gi))) begin
                            busy_reg[gi] <= False;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            cmt_valid   <= False;
            cmt_rob_id  <= '0;
            cmt_rd      <= '0;
            cmt_value   <= '0;
            flush_valid <= False;
            flush_pc    <= '0;
        end else if (rdy) begin
            cmt_valid   <= commit_fire;
            flush_valid <= flush_fire;
            if (commit_fire) begin
                cmt_rob_id <= head_reg;
                cmt_rd     <= rd_reg[head_reg];
                cmt_value  <= value_reg[head_reg];
            end
            if (flush_fire) begin
                flush_pc  <= taken_reg[head_reg] ? target_reg[head_reg]
                                                 : pc_reg[head_reg] + DATA_W'(4);
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (commit_fire) head_reg <= head_reg + ID_W'(1);
                if (disp_fire)   tail_reg <= tail_reg + ID_W'(1);
                count_reg <= count_next;
            end
        end else begin
            cmt_valid   <= False;
            flush_valid <= False;
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Self-checking bench for rob_multiport: directed scenarios plus randomized traffic
// checked against a queue-based model of the in-order commit rules.
module tb_rob_multiport;

    localparam int DEPTH = 16;
    localparam int WB    = 2;
    localparam int IDW   = 4;
    localparam int DW    = 32;
    localparam int RW    = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rdy = 1'b0;
    logic            disp_valid = 1'b0;
    logic [RW-1:0]   disp_rd = '0;
    logic [DW-1:0]   disp_pc = '0;
    logic            disp_is_br = 1'b0;
    logic            disp_pred_taken = 1'b0;
    logic            disp_ready;
    logic [IDW-1:0]  disp_rob_id;
    logic [WB-1:0]   wb_valid = '0;
    logic [WB*IDW-1:0] wb_rob_id = '0;
    logic [WB*DW-1:0]  wb_value = '0;
    logic [WB-1:0]     wb_taken = '0;
    logic [WB*DW-1:0]  wb_target = '0;
    logic [IDW-1:0]  qry_id_a = '0;
    logic [IDW-1:0]  qry_id_b = '0;
    logic            qry_ready_a, qry_ready_b;
    logic [DW-1:0]   qry_value_a, qry_value_b;
    logic            cmt_valid;
    logic [IDW-1:0]  cmt_rob_id;
    logic [RW-1:0]   cmt_rd;
    logic [DW-1:0]   cmt_value;
    logic            flush_valid;
    logic [DW-1:0]   flush_pc;
    logic [IDW:0]    count;

    int checks = 0;
    int errors = 0;

    rob_multiport #(.DEPTH(DEPTH), .WB_PORTS(WB), .DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_pc(disp_pc),
        .disp_is_br(disp_is_br), .disp_pred_taken(disp_pred_taken),
        .disp_ready(disp_ready), .disp_rob_id(disp_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_taken(wb_taken), .wb_target(wb_target),
        .qry_id_a(qry_id_a), .qry_id_b(qry_id_b),
        .qry_ready_a(qry_ready_a), .qry_ready_b(qry_ready_b),
        .qry_value_a(qry_value_a), .qry_value_b(qry_value_b),
        .cmt_valid(cmt_valid), .cmt_rob_id(cmt_rob_id), .cmt_rd(cmt_rd), .cmt_value(cmt_value),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && cmt_valid)
            $display("commit id=%0d rd=%0d value=%h%s", cmt_rob_id, cmt_rd, cmt_value,
                     flush_valid ? " redirect" : "");
    end

    // Reference model: program-order list of in-flight instructions.
    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [31:0] pc;
        bit          is_br;
        bit          pred;
        bit          done;
        logic [31:0] value;
        bit          taken;
        logic [31:0] target;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    bit          e_cmt_valid, e_flush_valid;
    int          e_cmt_id;
    logic [4:0]  e_cmt_rd;
    logic [31:0] e_cmt_value, e_flush_pc;

    task automatic model_clear();
        q.delete();
        m_tail = 0;
        e_cmt_valid = 0;
        e_flush_valid = 0;
    endtask

    task automatic model_edge();
        bit   com, mis, full;
        ent_t e;
        if (!rdy) begin
            e_cmt_valid = 0;
            e_flush_valid = 0;
            return;
        end
        full = (q.size() == DEPTH);
        com  = (q.size() > 0) && q[0].done;
        mis  = com && q[0].is_br && (q[0].pred != q[0].taken);
        e_cmt_valid = com;
        e_flush_valid = mis;
        if (com) begin
            e_cmt_id = q[0].id;
            e_cmt_rd = q[0].rd;
            e_cmt_value = q[0].value;
        end
        if (mis) begin
            e_flush_pc = q[0].taken ? q[0].target : q[0].pc + 32'd4;
            q.delete();
            m_tail = 0;
            return;
        end
        for (int p = WB - 1; p >= 0; p--) begin
            if (wb_valid[p]) begin
                foreach (q[i]) begin
                    if (q[i].id == int'(wb_rob_id[p*IDW +: IDW])) begin
                        e = q[i];
                        e.done = 1;
                        e.value = wb_value[p*DW +: DW];
                        e.taken = wb_taken[p];
                        e.target = wb_target[p*DW +: DW];
                        q[i] = e;
                    end
                end
            end
        end
        if (com) void'(q.pop_front());
        if (disp_valid && !full) begin
            e.id = m_tail; e.rd = disp_rd; e.pc = disp_pc; e.is_br = disp_is_br;
            e.pred = disp_pred_taken; e.done = 0; e.value = '0; e.taken = 0; e.target = '0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic exp_query(input logic [IDW-1:0] id, output bit known, output bit r,
                             output logic [31:0] v);
        known = 0; r = 0; v = '0;
        for (int p = WB - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_rob_id[p*IDW +: IDW] == id)) begin
                known = 1; r = 1; v = wb_value[p*DW +: DW];
            end
        end
        if (!known) begin
            foreach (q[i]) begin
                if (q[i].id == int'(id)) begin
                    known = 1; r = q[i].done; v = q[i].value;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        disp_valid = 0; disp_rd = '0; disp_pc = '0; disp_is_br = 0; disp_pred_taken = 0;
        wb_valid = '0; wb_rob_id = '0; wb_value = '0; wb_taken = '0; wb_target = '0;
    endtask

    task automatic set_disp(input bit v, input logic [4:0] rd, input logic [31:0] pc,
                            input bit br, input bit pred);
        disp_valid = v; disp_rd = rd; disp_pc = pc; disp_is_br = br; disp_pred_taken = pred;
    endtask

    task automatic set_wb(input int p, input int id, input logic [31:0] val, input bit tk,
                          input logic [31:0] tgt);
        wb_valid[p] = 1'b1;
        wb_rob_id[p*IDW +: IDW] = IDW'(id);
        wb_value[p*DW +: DW] = val;
        wb_taken[p] = tk;
        wb_target[p*DW +: DW] = tgt;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        #2;
        rst_n = 1;
        rdy = 1;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #2;
        checks++;
        if ({cmt_valid, flush_valid, disp_ready, count, disp_rob_id} !== {1'b0, 1'b0, 1'b1, 5'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b f=%b rdy=%b cnt=%0d id=%0d required 0 0 1 0 0",
                     cmt_valid, flush_valid, disp_ready, count, disp_rob_id);
        end
        checks++;
        if ({cmt_rob_id, cmt_rd, cmt_value, flush_pc, qry_ready_a} !== '0) begin
            errors++;
            $display("FAIL reset_data got id=%0d rd=%0d val=%h pc=%h qr=%b required all zero",
                     cmt_rob_id, cmt_rd, cmt_value, flush_pc, qry_ready_a);
        end
        do_reset();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_disp(1, 5'(i + 1), 32'(i * 4), 0, 0);
            if (i < 16) begin
                checks++;
                if (disp_rob_id !== 4'(i)) begin
                    errors++;
                    $display("FAIL fill_id got %0d required %0d", disp_rob_id, i);
                end
            end
            tick();
            if (i == 15) begin
                checks++;
                if ({count, disp_ready} !== {5'd16, 1'b0}) begin
                    errors++;
                    $display("FAIL fill_full got cnt=%0d rdy=%b required 16 0", count, disp_ready);
                end
            end
        end
        checks++;
        if ({count, disp_ready, disp_rob_id} !== {5'd16, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL fill_extra got cnt=%0d rdy=%b id=%0d required 16 0 0",
                     count, disp_ready, disp_rob_id);
        end
        clear_inputs();
    endtask

    task automatic test_out_of_order();
        int          got_id[$];
        logic [31:0] got_val[$];
        int          exp_id[3]  = '{0, 1, 2};
        logic [31:0] exp_val[3] = '{32'hB, 32'hC, 32'hA};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_disp(1, 5'(i + 1), 32'h40 + 32'(i * 4), 0, 0);
            tick();
        end
        clear_inputs();
        for (int k = 0; k < 7; k++) begin
            wb_valid = '0;
            if (k == 0) set_wb(0, 2, 32'hA, 0, 0);
            if (k == 1) set_wb(0, 0, 32'hB, 0, 0);
            if (k == 2) set_wb(1, 1, 32'hC, 0, 0);
            tick();
            if (cmt_valid) begin
                got_id.push_back(int'(cmt_rob_id));
                got_val.push_back(cmt_value);
            end
        end
        checks++;
        if (got_id.size() != 3) begin
            errors++;
            $display("FAIL ooo_count got %0d commits required 3", got_id.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ((got_id[i] != exp_id[i]) || (got_val[i] !== exp_val[i])) begin
                    errors++;
                    $display("FAIL ooo_commit%0d got id=%0d val=%h required id=%0d val=%h",
                             i, got_id[i], got_val[i], exp_id[i], exp_val[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int n_cmt = 0;
        do_reset();
        for (int k = 0; k < 44; k++) begin
            clear_inputs();
            if (k < 40) set_disp(1, 5'(k % 32), 32'(k * 4), 0, 0);
            if (k >= 1 && k <= 40) set_wb(0, (k - 1) % DEPTH, 32'h1000 + 32'(k - 1), 0, 0);
            tick();
            if (cmt_valid) begin
                checks++;
                if ({cmt_rob_id, cmt_value} !== {4'(n_cmt % DEPTH), 32'h1000 + 32'(n_cmt)}) begin
                    errors++;
                    $display("FAIL wrap_commit%0d got id=%0d val=%h required id=%0d val=%h", n_cmt,
                             cmt_rob_id, cmt_value, n_cmt % DEPTH, 32'h1000 + 32'(n_cmt));
                end
                n_cmt++;
            end
        end
        checks++;
        if ((n_cmt != 40) || (count !== 5'd0)) begin
            errors++;
            $display("FAIL wrap_total got commits=%0d cnt=%0d required 40 0", n_cmt, count);
        end
    endtask

    task automatic test_dual_wb();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_disp(1, 5'(i + 1), 32'(i * 4), 0, 0);
            tick();
        end
        clear_inputs();
        set_wb(0, 3, 32'h11, 0, 0);
        set_wb(1, 3, 32'h22, 0, 0);
        qry_id_a = 4'd3;
        #1;
        checks++;
        if ({qry_ready_a, qry_value_a} !== {1'b1, 32'h11}) begin
            errors++;
            $display("FAIL dual_bypass got rdy=%b val=%h required 1 00000011", qry_ready_a, qry_value_a);
        end
        tick();
        clear_inputs();
        qry_id_b = 4'd3;
        qry_id_a = 4'd2;
        #1;
        checks++;
        if ({qry_ready_b, qry_value_b, qry_ready_a} !== {1'b1, 32'h11, 1'b0}) begin
            errors++;
            $display("FAIL dual_stored got rdy3=%b val3=%h rdy2=%b required 1 00000011 0",
                     qry_ready_b, qry_value_b, qry_ready_a);
        end
    endtask

    task automatic test_mispredict();
        logic [31:0] bpc, epc;
        for (int s = 0; s < 2; s++) begin
            bpc = (s == 0) ? 32'h100 : 32'h300;
            epc = (s == 0) ? 32'h200 : 32'h304;
            do_reset();
            set_disp(1, 5'd0, bpc, 1, s[0]);
            tick();
            for (int i = 0; i < 3; i++) begin
                set_disp(1, 5'(i + 1), bpc + 32'(4 * (i + 1)), 0, 0);
                tick();
            end
            clear_inputs();
            set_wb(0, 0, 32'h0, ~s[0], 32'h200);
            tick();
            clear_inputs();
            set_disp(1, 5'd9, 32'h900, 0, 0);
            set_wb(0, 1, 32'h77, 0, 0);
            tick();
            checks++;
            if ({cmt_valid, cmt_rob_id, flush_valid, flush_pc} !== {1'b1, 4'd0, 1'b1, epc}) begin
                errors++;
                $display("FAIL mispredict%0d got cv=%b id=%0d fv=%b pc=%h required 1 0 1 %h",
                         s, cmt_valid, cmt_rob_id, flush_valid, flush_pc, epc);
            end
            checks++;
            if ({count, disp_rob_id} !== {5'd0, 4'd0}) begin
                errors++;
                $display("FAIL flush_state%0d got cnt=%0d id=%0d required 0 0", s, count, disp_rob_id);
            end
            tick();
            checks++;
            if ({flush_valid, cmt_valid, count, disp_rob_id} !== {1'b0, 1'b0, 5'd1, 4'd1}) begin
                errors++;
                $display("FAIL post_flush%0d got fv=%b cv=%b cnt=%0d id=%0d required 0 0 1 1",
                         s, flush_valid, cmt_valid, count, disp_rob_id);
            end
            clear_inputs();
        end
    endtask

    task automatic test_freeze_and_reset();
        do_reset();
        set_disp(1, 5'd7, 32'h50, 0, 0);
        tick();
        clear_inputs();
        set_wb(0, 0, 32'h55, 0, 0);
        tick();
        clear_inputs();
        rdy = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({cmt_valid, count} !== {1'b0, 5'd1}) begin
                errors++;
                $display("FAIL freeze%0d got cv=%b cnt=%0d required 0 1", i, cmt_valid, count);
            end
        end
        rdy = 1;
        tick();
        checks++;
        if ({cmt_valid, cmt_rd, cmt_value, count} !== {1'b1, 5'd7, 32'h55, 5'd0}) begin
            errors++;
            $display("FAIL thaw got cv=%b rd=%0d val=%h cnt=%0d required 1 7 00000055 0",
                     cmt_valid, cmt_rd, cmt_value, count);
        end
        for (int i = 0; i < 3; i++) begin
            set_disp(1, 5'(i + 2), 32'h60, 0, 0);
            tick();
        end
        clear_inputs();
        set_wb(0, 1, 32'h66, 0, 0);
        tick();
        clear_inputs();
        tick();
        rst_n = 0;
        #1;
        checks++;
        if ({cmt_valid, flush_valid, disp_ready, count, disp_rob_id, cmt_rob_id, cmt_value}
            !== {1'b0, 1'b0, 1'b1, 5'd0, 4'd0, 4'd0, 32'd0}) begin
            errors++;
            $display("FAIL midrun_reset got cv=%b fv=%b rdy=%b cnt=%0d id=%0d cid=%0d val=%h",
                     cmt_valid, flush_valid, disp_ready, count, disp_rob_id, cmt_rob_id, cmt_value);
        end
        #1;
        do_reset();
    endtask

    task automatic test_random();
        bit          ka, kb, ra, rb;
        logic [31:0] va, vb;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6)
                set_disp(1, 5'($urandom), {$urandom_range(0, 255), 2'b00}, ($urandom_range(0, 3) == 0),
                         1'($urandom));
            for (int p = 0; p < WB; p++) begin
                if ($urandom_range(0, 9) < 4) begin
                    if ((q.size() > 0) && ($urandom_range(0, 3) != 0))
                        set_wb(p, q[$urandom_range(0, q.size() - 1)].id, $urandom, 1'($urandom), $urandom);
                    else
                        set_wb(p, $urandom_range(0, DEPTH - 1), $urandom, 1'($urandom), $urandom);
                end
            end
            qry_id_a = IDW'($urandom);
            qry_id_b = (q.size() > 0) ? IDW'(q[0].id) : IDW'($urandom);
            #1;
            exp_query(qry_id_a, ka, ra, va);
            exp_query(qry_id_b, kb, rb, vb);
            if (ka) begin
                checks++;
                if ((qry_ready_a !== ra) || (ra && (qry_value_a !== va))) begin
                    errors++;
                    $display("FAIL rnd_qry_a c=%0d id=%0d got %b/%h required %b/%h",
                             c, qry_id_a, qry_ready_a, qry_value_a, ra, va);
                end
            end
            if (kb) begin
                checks++;
                if ((qry_ready_b !== rb) || (rb && (qry_value_b !== vb))) begin
                    errors++;
                    $display("FAIL rnd_qry_b c=%0d id=%0d got %b/%h required %b/%h",
                             c, qry_id_b, qry_ready_b, qry_value_b, rb, vb);
                end
            end
            tick();
            checks++;
            if ({cmt_valid, flush_valid, count, disp_rob_id, disp_ready}
                !== {e_cmt_valid, e_flush_valid, 5'(q.size()), 4'(m_tail), (q.size() != DEPTH)}) begin
                errors++;
                $display("FAIL rnd_ctrl c=%0d got cv=%b fv=%b cnt=%0d id=%0d rdy=%b required %b %b %0d %0d",
                         c, cmt_valid, flush_valid, count, disp_rob_id, disp_ready,
                         e_cmt_valid, e_flush_valid, q.size(), m_tail);
            end
            if (e_cmt_valid) begin
                checks++;
                if ({cmt_rob_id, cmt_rd, cmt_value} !== {4'(e_cmt_id), e_cmt_rd, e_cmt_value}) begin
                    errors++;
                    $display("FAIL rnd_cmt c=%0d got id=%0d rd=%0d val=%h required id=%0d rd=%0d val=%h",
                             c, cmt_rob_id, cmt_rd, cmt_value, e_cmt_id, e_cmt_rd, e_cmt_value);
                end
            end
            if (e_flush_valid) begin
                checks++;
                if (flush_pc !== e_flush_pc) begin
                    errors++;
                    $display("FAIL rnd_flush_pc c=%0d got %h required %h", c, flush_pc, e_flush_pc);
                end
            end
        end
        clear_inputs();
        rdy = 1;
    endtask

    initial begin
        model_clear();
        #3;
        test_reset();
        test_fill();
        test_out_of_order();
        test_wrap();
        test_dual_wb();
        test_mispredict();
        test_freeze_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
